// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg: upstream in_* channel,
// downstream out_* channel and the occupancy count.
interface pipe_skid_reg_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       count;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, count
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer: full-rate valid/ready pipeline register whose
// in_ready, out_valid and count are all driven straight from flops.
module pipe_skid_reg #(
  parameter int WIDTH = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  pipe_skid_reg_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_count;

  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;
  logic             w_next_in_ready;
  logic             w_next_out_valid;
  logic [1:0]       w_next_count;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;

    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_next_state   = ST_BUSY;
          w_load_main_in = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_next_state = ST_FULL;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_next_state = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_next_state     = ST_BUSY;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase

    // Flush wins over any transfer; an accepted input word is simply dropped.
    if (flush) begin
      w_next_state     = ST_EMPTY;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
    end

    w_next_in_ready  = (w_next_state != ST_FULL);
    w_next_out_valid = (w_next_state != ST_EMPTY);
    unique case (w_next_state)
      ST_BUSY: w_next_count = 2'd1;
      ST_FULL: w_next_count = 2'd2;
      default: w_next_count = 2'd0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_next_state;
      r_in_ready  <= w_next_in_ready;
      r_out_valid <= w_next_out_valid;
      r_count     <= w_next_count;
    end
  end

  // NOTE: the data registers carry a defined reset value, but flush and drain leave their contents alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= bus.in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= bus.in_data;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign bus.count     = r_count;

  a_no_in_fire_when_full : assert property (
    @(posedge clk) disable iff (!reset) (r_state == ST_FULL) |-> !w_in_fire
  );

endmodule
